// File: rtl/usb_tx_packetizer_if.sv
// Endpoint-side byte stream plus ULPI transmit signals for the USB TX packetizer.
// The packetizer uses the slave modport; the endpoint/PHY side uses master.
interface usb_tx_packetizer_if;
  logic [7:0] data_i;
  logic       data_i_start_stop;
  logic       data_i_strb;
  logic       data_i_fail;
  logic [7:0] ulpi_data_o;
  logic       ulpi_stp;
  logic       ulpi_nxt;
  logic       ulpi_dir;
  logic       busy;

  modport master (
    output data_i, data_i_start_stop, ulpi_nxt, ulpi_dir,
    input  data_i_strb, data_i_fail, ulpi_data_o, ulpi_stp, busy
  );

  modport slave (
    input  data_i, data_i_start_stop, ulpi_nxt, ulpi_dir,
    output data_i_strb, data_i_fail, ulpi_data_o, ulpi_stp, busy
  );
endinterface

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: frames endpoint bytes into a ULPI TX command, payload,
// CRC-16 (DATA PIDs only) and a one-cycle stop.
module usb_tx_packetizer (
  input logic                clk,
  input logic                nrst,
  usb_tx_packetizer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StTxCmd, StTxData, StTxCrcLo, StTxCrcHi, StTxStop
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] crc_q, crc_d;
  logic        fail_q, fail_d;
  logic        pid_ok, accept;

  // CRC-16/USB, reflected polynomial, one byte LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign pid_ok = (bus.data_i[7:4] == ~bus.data_i[3:0]);
  assign accept = bus.ulpi_nxt & ~bus.ulpi_dir;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      pid_q   <= 4'h0;
      hold_q  <= 8'h00;
      crc_q   <= 16'hFFFF;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      hold_q  <= hold_d;
      crc_q   <= crc_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    hold_d  = hold_q;
    crc_d   = crc_q;
    fail_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.data_i_start_stop) begin
          if (pid_ok && !bus.ulpi_dir) begin
            pid_d   = bus.data_i[3:0];
            crc_d   = 16'hFFFF;
            state_d = StTxCmd;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      StTxCmd, StTxData: begin
        if (bus.ulpi_dir) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else if (bus.ulpi_nxt) begin
          // The byte just accepted in TX_DATA is the holding register; fold it in now.
          if (state_q == StTxData) crc_d = crc16_byte(crc_q, hold_q);
          if (!bus.data_i_start_stop) begin
            hold_d  = bus.data_i;
            state_d = StTxData;
          end else begin
            state_d = (pid_q[1:0] == 2'b11) ? StTxCrcLo : StTxStop;
          end
        end
      end
      StTxCrcLo: begin
        if (bus.ulpi_dir) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else if (bus.ulpi_nxt) begin
          state_d = StTxCrcHi;
        end
      end
      StTxCrcHi: begin
        if (bus.ulpi_dir) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else if (bus.ulpi_nxt) begin
          state_d = StTxStop;
        end
      end
      StTxStop: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ulpi_data_o = 8'h00;
    bus.ulpi_stp    = 1'b0;
    bus.data_i_strb = 1'b0;
    unique case (state_q)
      StTxCmd: begin
        bus.ulpi_data_o = {4'b0100, pid_q};
        bus.data_i_strb = accept;
      end
      StTxData: begin
        bus.ulpi_data_o = hold_q;
        bus.data_i_strb = accept;
      end
      StTxCrcLo: bus.ulpi_data_o = ~crc_q[7:0];
      StTxCrcHi: bus.ulpi_data_o = ~crc_q[15:8];
      StTxStop:  bus.ulpi_stp = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.data_i_fail = fail_q;

endmodule

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: nrst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: data_i  in  8  byte from endpoint controller; PID on the first byte.
REQ-004 SHALL have ports: data_i_start_stop  in  1  in IDLE, starts a packet; during an strb cycle, ends the packet.
REQ-005 SHALL have ports: data_i_strb  out  1  one-cycle pulse; current byte consumed, upstream answers in the same cycle.
REQ-006 SHALL have ports: data_i_fail  out  1  one-cycle pulse; packet rejected or aborted.
REQ-007 SHALL have ports: ulpi_data_o  out  8  ULPI transmit data.
REQ-008 SHALL have ports: ulpi_stp  out  1  ULPI stop.
REQ-009 SHALL have ports: ulpi_nxt  in  1  PHY accepted current byte.
REQ-010 SHALL have ports: ulpi_dir  in  1  PHY owns bus.
REQ-011 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, TX_CMD, TX_DATA, TX_CRC_LO, TX_CRC_HI, TX_STOP.
REQ-013 SHALL, in IDLE with start_stop=1 and dir=0, latch data_i as pid, set crc=16'hFFFF and enter TX_CMD.
REQ-014 SHALL reject a start on an invalid PID (data_i[7:4] != ~data_i[3:0]) or on dir=1: pulse data_i_fail next cycle and stay in IDLE.
REQ-015 SHALL drive ulpi_data_o={4'b0100,pid[3:0]} in TX_CMD, held until nxt=1.
REQ-016 SHALL, in TX_CMD or TX_DATA, assert data_i_strb combinationally exactly when ulpi_nxt=1 and dir=0, and in that cycle sample data_i_start_stop and data_i.
REQ-017 SHALL, on strb with start_stop=0, latch data_i into the holding register and go to TX_DATA.
REQ-018 SHALL, on strb with start_stop=1, go to TX_CRC_LO if pid[1:0]==2'b11 (DATA PID), else to TX_STOP.
REQ-019 SHALL drive the holding register on ulpi_data_o in TX_DATA; on nxt it updates crc with that byte.
REQ-020 SHALL compute CRC-16/USB as reflected polynomial 16'hA001, LSB-first, init 16'hFFFF, over data bytes only (PID excluded), one byte per accepted cycle.
REQ-021 SHALL drive ~crc[7:0] in TX_CRC_LO and ~crc[15:8] in TX_CRC_HI, each advancing on nxt; TX_CRC_HI advances to TX_STOP.
REQ-022 SHALL drive ulpi_stp=1 and ulpi_data_o=8'h00 in TX_STOP for exactly one cycle, then return to IDLE.
REQ-023 SHALL drive ulpi_data_o=8'h00 and ulpi_stp=0 in IDLE.
REQ-024 SHALL hold the current byte, crc and state while nxt=0, with no cycle limit.
REQ-025 SHALL, if dir=1 in any non-IDLE state other than TX_STOP, abort: pulse data_i_fail next cycle, go to IDLE, issue no stp and no strb.
REQ-026 SHALL ignore data_i_start_stop outside IDLE and outside strb cycles.
REQ-027 SHALL allow a new start in the cycle immediately after TX_STOP.

Reset
REQ-028 SHALL, on nrst=0, asynchronously set state=IDLE, pid=0, holding=0, crc=16'hFFFF, and drive all outputs 0.
REQ-029 SHALL, on nrst asserted mid-packet, drop the packet with no stp and no fail pulse.

Verification
REQ-030 SHALL cover ACK: start with D2 -> ulpi_data_o=0x42 until nxt; strb with start_stop=1 -> next cycle stp=1, data 0x00; no CRC bytes.
REQ-031 SHALL cover zero-length DATA1: start with 4B -> 0x4B; end on first strb -> 0x00, 0x00, then stp.
REQ-032 SHALL cover DATA0 with payload 31..39 ("123456789"), nxt held high -> 0x43, 31..39, C8, B4, stp.
REQ-033 SHALL cover nxt low for 5 cycles in TX_DATA -> byte stable, no strb, crc unchanged, final CRC identical to REQ-032.
REQ-034 SHALL cover dir=1 during the third data byte -> one fail pulse, busy=0 next cycle, no stp; and start with C4 -> fail pulse, no transmit.
REQ-035 SHALL cover nrst pulse during TX_CRC_LO -> all outputs 0 immediately; a following ACK packet transmits correctly.
